// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared defaults and helpers for the trigger counter bank
package trigger_pkg;

  localparam int DEF_NCHAN = 5;
  localparam int DEF_CNT_W = 20;

  // Channel-index width: ceil(log2(n)), never narrower than one bit.
  function automatic int chan_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/trigger_chan_counter.sv
// rtl/trigger_chan_counter.sv - one channel: live saturating counter plus frozen snapshot
module trigger_chan_counter
  import trigger_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swap,
  input  logic             trig,
  output logic [CNT_W-1:0] live_cnt,
  output logic             live_sat,
  output logic [CNT_W-1:0] snap_cnt,
  output logic             snap_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count triggers into the live buffer; on swap freeze the old count and
  // restart, with a trigger in the swap cycle credited to the new buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_cnt <= '0;
      live_sat <= 1'b0;
      snap_cnt <= '0;
      snap_sat <= 1'b0;
    end else if (swap) begin
      snap_cnt <= live_cnt;
      snap_sat <= live_sat;
      live_cnt <= trig ? CNT_W'(1) : '0;
      live_sat <= 1'b0;
    end else if (trig) begin
      if (live_cnt == CNT_MAX) begin
        live_sat <= 1'b1;
      end else begin
        live_cnt <= live_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/trigger_counter_bank.sv
// rtl/trigger_counter_bank.sv - per-channel trigger counters with double-buffered snapshot readout
module trigger_counter_bank
  import trigger_pkg::*;
#(
  parameter int NCHAN = DEF_NCHAN,
  parameter int CNT_W = DEF_CNT_W,
  parameter int CH_W  = chan_w(NCHAN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   swap,
  input  logic [NCHAN-1:0]       trig,
  output logic [NCHAN*CNT_W-1:0] live_cnt,
  output logic [NCHAN-1:0]       live_sat,
  input  logic                   rd_req,
  input  logic [CH_W-1:0]        rd_chan,
  output logic                   rd_valid,
  output logic [CNT_W-1:0]       rd_data,
  output logic                   rd_sat,
  output logic                   rd_err,
  output logic                   snap_pending,
  output logic                   snap_overrun
);

  logic [CNT_W-1:0] snap_cnt [NCHAN];
  logic [NCHAN-1:0] snap_sat;

  logic [NCHAN-1:0] rd_mask;
  logic [NCHAN-1:0] rd_mask_nxt;
  logic             swap_seen;
  logic             swap_seen_nxt;
  logic             pending_nxt;

  logic [NCHAN-1:0] rd_onehot;
  logic             rd_hit;
  logic [CNT_W-1:0] rd_mux_data;
  logic             rd_mux_sat;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    trigger_chan_counter #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .swap    (swap),
      .trig    (trig[i]),
      .live_cnt(live_cnt[i*CNT_W +: CNT_W]),
      .live_sat(live_sat[i]),
      .snap_cnt(snap_cnt[i]),
      .snap_sat(snap_sat[i])
    );
  end

  // Decode the requested channel; out-of-range indices select nothing.
  always_comb begin
    rd_onehot   = '0;
    rd_mux_data = '0;
    rd_mux_sat  = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (rd_chan == CH_W'(i)) begin
        rd_onehot[i] = 1'b1;
        rd_mux_data  = snap_cnt[i];
        rd_mux_sat   = snap_sat[i];
      end
    end
    rd_hit = |rd_onehot;
  end

  // Next read-mask state: a swap wins over a same-cycle read, so that read
  // never marks the freshly taken snapshot.
  always_comb begin
    rd_mask_nxt = rd_mask;
    if (swap) begin
      rd_mask_nxt = '0;
    end else if (rd_req) begin
      rd_mask_nxt = rd_mask | rd_onehot;
    end
    swap_seen_nxt = swap_seen | swap;
    pending_nxt   = swap_seen_nxt & ~(&rd_mask_nxt);
  end

  // Read-tracking, overrun and the registered read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_mask      <= '0;
      swap_seen    <= 1'b0;
      snap_pending <= 1'b0;
      snap_overrun <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_sat       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      rd_mask      <= rd_mask_nxt;
      swap_seen    <= swap_seen_nxt;
      snap_pending <= pending_nxt;
      if (swap && snap_pending) begin
        snap_overrun <= 1'b1;
      end
      rd_valid <= rd_req;
      rd_err   <= rd_req & ~rd_hit;
      rd_data  <= (rd_req && rd_hit) ? rd_mux_data : '0;
      rd_sat   <= rd_req & rd_hit & rd_mux_sat;
    end
  end

endmodule

// File: doc/trigger_counter_bank.md
# trigger_counter_bank

Parametrised bank of per-channel self-trigger counters with double-buffered snapshots. Each channel counts self-triggers into the currently active memory buffer. On a buffer switch, every channel's count is frozen into a snapshot register and the live counter restarts. The fill-readout logic reads snapshots one channel per request over a simple request/valid handshake, while live counting continues for the new buffer.

## Interface
Parameters:
- NCHAN, 5, number of channels.
- CNT_W, 20, counter/snapshot width in bits.
- CH_W, $clog2(NCHAN) (min 1), channel-index width.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- swap  in  1  one-cycle pulse: the active memory buffer switches this cycle.
- trig  in  NCHAN  per-channel self-trigger enables, one count per high cycle.
- live_cnt  out  NCHAN*CNT_W  live counters; channel i is at [i*CNT_W +: CNT_W].
- live_sat  out  NCHAN  per-channel saturation flag for the live buffer.
- rd_req  in  1  snapshot read request.
- rd_chan  in  CH_W  channel to read.
- rd_valid  out  1  one-cycle pulse with read data.
- rd_data  out  CNT_W  snapshot count.
- rd_sat  out  1  snapshot saturation flag.
- rd_err  out  1  rd_chan >= NCHAN. Qualified by rd_valid.
- snap_pending  out  1  snapshot taken and not yet fully read.
- snap_overrun  out  1  sticky: a swap overwrote unread snapshots.

## Operation
- Live counter per channel:
  - On reset: 0, sat=0.
  - On swap: load trig[i] ? 1 : 0, sat=0. The trigger in the swap cycle belongs to the new buffer.
  - Otherwise, if trig[i] and count < 2^CNT_W-1: increment.
  - If trig[i] at max: hold max and set sat. No wrap.
- Snapshot on swap: snap[i] <= live count before the update, snap_sat[i] <= live_sat[i], for all channels simultaneously.
- Read-tracking:
  - A read mask of NCHAN bits is cleared on swap.
  - Each valid read (rd_chan < NCHAN) sets mask[rd_chan].
  - snap_pending = any swap since reset and mask not all-ones.
  - Repeated reads of the same channel are allowed and return the same data.
- Overrun: a swap while snap_pending=1 sets snap_overrun, which stays set until reset. The new snapshot still overwrites the old one.
- Read path:
  - rd_req in cycle N gives rd_valid=1 in cycle N+1, with rd_data/rd_sat = snap[rd_chan] as registered at the end of cycle N.
  - rd_req is accepted every cycle. There is no back-pressure.
  - Invalid channel: rd_data=0, rd_sat=0, rd_err=1. The mask is unchanged.
- Swap and rd_req in the same cycle: the read returns the pre-swap snapshot, and the mask is cleared by the swap. The read does not mark the new snapshot.
- Reset mid-operation: all counters, snapshots, flags, mask and overrun return to 0. Any in-flight read is dropped, so rd_valid=0 in the next cycle.

## Timing
- Reset values: live_cnt=0, live_sat=0, rd_valid=0, rd_data=0, rd_sat=0, rd_err=0, snap_pending=0, snap_overrun=0.
- All outputs are registered. Nothing passes combinationally from input to output.
- trig in cycle N is visible on live_cnt in cycle N+1.
- swap in cycle N gives snapshot and snap_pending=1 in cycle N+1.
- Read latency is exactly 1 cycle, with throughput of 1 read per cycle.
- snap_pending falls in the cycle after the last unread channel's rd_req.

## Structure
- Shared package trigger_pkg holds the default NCHAN/CNT_W and a function for CH_W (clog2, minimum 1).
- One sub-module, trigger_chan_counter, per channel: live count, saturation flag and snapshot, instantiated NCHAN times via generate.
- The top level holds the read mux, read mask, pending and overrun logic.

## Test plan
- Reset, then trig[0] high for 7 cycles and trig[2] for 3 -> live_cnt ch0=7, ch2=3, others 0. Then swap -> rd ch0=7, ch2=3, live ch0..2=0.
- CNT_W=4: trig[1] for 20 cycles -> live_cnt ch1=15, live_sat[1]=1. Swap -> rd_data=15, rd_sat=1, live_sat cleared.
- Swap with trig[3] high in the same cycle, with prior count 9 -> snapshot ch3=9, live ch3=1.
- Swap, read channels 0..NCHAN-1 back-to-back -> rd_valid every cycle, snap_pending drops after the last read. A second swap gives snap_overrun=0.
- Swap, read ch0 only, swap again -> snap_overrun=1, held through further swaps until reset.
- rd_chan=NCHAN -> rd_valid=1, rd_err=1, rd_data=0, mask unchanged. Reset asserted the cycle after an rd_req -> rd_valid=0 and all outputs 0.
